// File: rtl/smart_home_pkg.sv
// Shared types and constants for the smart-home event sequencer.
// Sensor indices double as priority rank: a lower index wins arbitration.
package smart_home_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [2:0] DISP_IDLE   = 3'b000;
  localparam logic [2:0] DISP_FRONT  = 3'b001;
  localparam logic [2:0] DISP_REAR   = 3'b010;
  localparam logic [2:0] DISP_WINDOW = 3'b011;
  localparam logic [2:0] DISP_HEATER = 3'b100;
  localparam logic [2:0] DISP_COOLER = 3'b101;
  localparam logic [2:0] DISP_FIRE   = 3'b110;

  localparam int NUM_SENSORS = 4;

  localparam logic [1:0] SENS_SFA = 2'd0;
  localparam logic [1:0] SENS_SFD = 2'd1;
  localparam logic [1:0] SENS_SRD = 2'd2;
  localparam logic [1:0] SENS_SW  = 2'd3;

endpackage

// File: rtl/sensor_debounce.sv
// Single-sensor debouncer: the clean value follows raw only after raw has
// disagreed with it for DEB_CYCLES consecutive clock edges.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw,
  output logic clean
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt;

  // The edge that would bring the count to DEB_CYCLES flips clean instead.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (raw == clean) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      cnt   <= '0;
      clean <= raw;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/smart_home_event_sequencer.sv
// Debounces four sensors, arbitrates them by fixed priority onto shared actuators,
// and runs hysteretic climate control when idle. Define ALARM_LATCH_EN to require ack.
module smart_home_event_sequencer
  import smart_home_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int T_LOW       = 50,
  parameter int T_HIGH      = 70,
  parameter int HYST        = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SW,
  input  logic       SFA,
  input  logic [6:0] ST,
  input  logic       ack,
  output logic       fdoor,
  output logic       rdoor,
  output logic       winbuzz,
  output logic       alarmbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic       busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [6:0] HEAT_ON  = 7'(T_LOW);
  localparam logic [6:0] HEAT_OFF = 7'(T_LOW + HYST);
  localparam logic [6:0] COOL_ON  = 7'(T_HIGH);
  localparam logic [6:0] COOL_OFF = 7'(T_HIGH - HYST);

  logic [NUM_SENSORS-1:0] raw_vec;
  logic [NUM_SENSORS-1:0] clean;
  state_t                 state, state_n;
  logic [1:0]             grant, grant_n;
  logic [HW-1:0]          hold, hold_n;
  logic                   req_any;
  logic [1:0]             req_top;
  logic [6:0]             st_r;
  logic                   heat_r, cool_r;

`ifndef ALARM_LATCH_EN
  logic ack_unused;
  assign ack_unused = ack;
`endif

  assign raw_vec = {SW, SRD, SFD, SFA};

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_deb
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .Clk  (Clk),
      .Rst  (Rst),
      .raw  (raw_vec[g]),
      .clean(clean[g])
    );
  end

  // Highest-priority non-fire request; fire is handled separately as a preemption.
  always_comb begin
    req_any = 1'b1;
    req_top = SENS_SFD;
    if (clean[SENS_SFD])      req_top = SENS_SFD;
    else if (clean[SENS_SRD]) req_top = SENS_SRD;
    else if (clean[SENS_SW])  req_top = SENS_SW;
    else                      req_any = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      grant <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      hold  <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    hold_n  = hold;
    unique case (state)
      IDLE: begin
        if (clean[SENS_SFA]) begin
          state_n = ALARM;
        end else if (req_any) begin
          state_n = SERVE;
          grant_n = req_top;
          hold_n  = HOLD_LOAD;
        end
      end
      SERVE: begin
        if (clean[SENS_SFA]) begin
          state_n = ALARM;
        end else if (hold != '0) begin
          hold_n = hold - 1'b1;
        end else if (!clean[grant]) begin
          state_n = IDLE;
        end else if (req_top < grant) begin
          grant_n = req_top;
          hold_n  = HOLD_LOAD;
        end
      end
      ALARM: begin
`ifdef ALARM_LATCH_EN
        if (ack && !clean[SENS_SFA]) state_n = IDLE;
`else
        if (!clean[SENS_SFA]) state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // ST sampling is a plain pipeline stage so climate resumes from a real reading after reset.
  always_ff @(posedge Clk) begin
    st_r <= ST;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      heat_r <= 1'b0;
      cool_r <= 1'b0;
    end else if (state == ALARM) begin
      heat_r <= 1'b0;
      cool_r <= 1'b0;
    end else if (state == IDLE && !req_any && !clean[SENS_SFA]) begin
      if (st_r < HEAT_ON)        heat_r <= 1'b1;
      else if (st_r >= HEAT_OFF) heat_r <= 1'b0;
      if (st_r > COOL_ON)        cool_r <= 1'b1;
      else if (st_r <= COOL_OFF) cool_r <= 1'b0;
    end
  end

  always_comb begin
    fdoor     = 1'b0;
    rdoor     = 1'b0;
    winbuzz   = 1'b0;
    alarmbuzz = 1'b0;
    heater    = 1'b0;
    cooler    = 1'b0;
    display   = DISP_IDLE;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        heater = heat_r;
        cooler = cool_r;
        if (heat_r)      display = DISP_HEATER;
        else if (cool_r) display = DISP_COOLER;
      end
      SERVE: begin
        heater = heat_r;
        cooler = cool_r;
        case (grant)
          SENS_SFD: begin fdoor   = 1'b1; display = DISP_FRONT;  end
          SENS_SRD: begin rdoor   = 1'b1; display = DISP_REAR;   end
          SENS_SW:  begin winbuzz = 1'b1; display = DISP_WINDOW; end
          default:  ;
        endcase
      end
      ALARM: begin
        alarmbuzz = 1'b1;
        display   = DISP_FIRE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smart_home_event_sequencer.sv
// Directed self-checking bench for smart_home_event_sequencer (default parameters).
// Follows ALARM_LATCH_EN the same way the design does.
module tb_smart_home_event_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       SFD, SRD, SW, SFA, ack;
  logic [6:0] ST;
  logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, busy;
  logic [2:0] display;

  int passCount  = 0;
  int totalCount = 0;

  smart_home_event_sequencer dut (
    .Clk(Clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .ack(ack), .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz),
    .alarmbuzz(alarmbuzz), .heater(heater), .cooler(cooler),
    .display(display), .busy(busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    if ({fdoor, rdoor, winbuzz, alarmbuzz} !== 4'b0000) $display("[TB] FAIL reset_act: got %b required 0000", {fdoor, rdoor, winbuzz, alarmbuzz});
    else passCount++;
    totalCount++;
    if ({heater, cooler, busy} !== 3'b000) $display("[TB] FAIL reset_clim_busy: got %b required 000", {heater, cooler, busy});
    else passCount++;
    totalCount++;
    if (display !== 3'b000) $display("[TB] FAIL reset_display: got %b required 000", display);
    else passCount++;
    totalCount++;
  endtask

  task automatic test_glitch();
    SFD = 1'b1;
    step(3);
    SFD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (fdoor !== 1'b0 || display !== 3'b000) $display("[TB] FAIL glitch_%0d: fdoor=%b display=%b required 0/000", i, fdoor, display);
      else passCount++;
      totalCount++;
    end
  endtask

  task automatic test_front_hold();
    SFD = 1'b1;
    step(4);
    if (fdoor !== 1'b0) $display("[TB] FAIL fd_edge4: got %b required 0", fdoor);
    else passCount++;
    totalCount++;
    step(1);
    if (fdoor !== 1'b1 || display !== 3'b001 || busy !== 1'b1) $display("[TB] FAIL fd_edge5: fdoor=%b display=%b busy=%b required 1/001/1", fdoor, display, busy);
    else passCount++;
    totalCount++;
    step(5);
    SFD = 1'b0;
    step(10);
    if (fdoor !== 1'b1) $display("[TB] FAIL fd_edge20: got %b required 1", fdoor);
    else passCount++;
    totalCount++;
    step(1);
    if (fdoor !== 1'b0 || display !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL fd_edge21: fdoor=%b display=%b busy=%b required 0/000/0", fdoor, display, busy);
    else passCount++;
    totalCount++;
    step(4);
  endtask

  task automatic test_priority();
    SFD = 1'b1;
    SW  = 1'b1;
    step(5);
    if (fdoor !== 1'b1 || winbuzz !== 1'b0 || display !== 3'b001) $display("[TB] FAIL prio_first: fdoor=%b winbuzz=%b display=%b required 1/0/001", fdoor, winbuzz, display);
    else passCount++;
    totalCount++;
    SFD = 1'b0;
    step(15);
    if (fdoor !== 1'b1) $display("[TB] FAIL prio_hold_end: fdoor=%b required 1", fdoor);
    else passCount++;
    totalCount++;
    step(1);
    if (busy !== 1'b0 || winbuzz !== 1'b0) $display("[TB] FAIL prio_idle_gap: busy=%b winbuzz=%b required 0/0", busy, winbuzz);
    else passCount++;
    totalCount++;
    step(1);
    if (winbuzz !== 1'b1 || display !== 3'b011) $display("[TB] FAIL prio_window: winbuzz=%b display=%b required 1/011", winbuzz, display);
    else passCount++;
    totalCount++;
    SW = 1'b0;
    step(20);
    if (busy !== 1'b0 || winbuzz !== 1'b0) $display("[TB] FAIL prio_done: busy=%b winbuzz=%b required 0/0", busy, winbuzz);
    else passCount++;
    totalCount++;
  endtask

  task automatic test_fire_preempt();
    SRD = 1'b1;
    step(12);
    if (rdoor !== 1'b1 || display !== 3'b010) $display("[TB] FAIL fire_rear: rdoor=%b display=%b required 1/010", rdoor, display);
    else passCount++;
    totalCount++;
    SFA = 1'b1;
    step(4);
    if (rdoor !== 1'b1 || alarmbuzz !== 1'b0) $display("[TB] FAIL fire_edge4: rdoor=%b alarmbuzz=%b required 1/0", rdoor, alarmbuzz);
    else passCount++;
    totalCount++;
    step(1);
    if (alarmbuzz !== 1'b1 || rdoor !== 1'b0 || display !== 3'b110) $display("[TB] FAIL fire_edge5: alarmbuzz=%b rdoor=%b display=%b required 1/0/110", alarmbuzz, rdoor, display);
    else passCount++;
    totalCount++;
    if (heater !== 1'b0 || cooler !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL fire_outputs: heater=%b cooler=%b busy=%b required 0/0/1", heater, cooler, busy);
    else passCount++;
    totalCount++;
`ifdef ALARM_LATCH_EN
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    if (alarmbuzz !== 1'b1) $display("[TB] FAIL ack_with_fire: alarmbuzz=%b required 1", alarmbuzz);
    else passCount++;
    totalCount++;
`endif
    SFA = 1'b0;
    SRD = 1'b0;
    step(4);
    if (alarmbuzz !== 1'b1) $display("[TB] FAIL fire_clean_fall: alarmbuzz=%b required 1", alarmbuzz);
    else passCount++;
    totalCount++;
`ifdef ALARM_LATCH_EN
    step(4);
    if (alarmbuzz !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL latch_no_ack: alarmbuzz=%b busy=%b required 1/1", alarmbuzz, busy);
    else passCount++;
    totalCount++;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
`else
    step(1);
`endif
    if (alarmbuzz !== 1'b0 || busy !== 1'b0 || display !== 3'b000) $display("[TB] FAIL fire_exit: alarmbuzz=%b busy=%b display=%b required 0/0/000", alarmbuzz, busy, display);
    else passCount++;
    totalCount++;
    step(2);
  endtask

  task automatic test_climate();
    logic [6:0] stSeq [6]  = '{7'd55, 7'd49, 7'd51, 7'd52, 7'd71, 7'd68};
    logic [4:0] expSeq [6] = '{ {1'b0, 1'b0, 3'b000}, {1'b1, 1'b0, 3'b100}, {1'b1, 1'b0, 3'b100},
                                {1'b0, 1'b0, 3'b000}, {1'b0, 1'b1, 3'b101}, {1'b0, 1'b0, 3'b000} };
    for (int i = 0; i < 6; i++) begin
      ST = stSeq[i];
      step(1);
      if (i == 1 && heater !== 1'b0) begin
        $display("[TB] FAIL clim_latency: heater=%b required 0 one edge after ST=49", heater);
      end else if (i == 1) passCount++;
      if (i == 1) totalCount++;
      step(1);
      if ({heater, cooler, display} !== expSeq[i]) $display("[TB] FAIL clim_st%0d: heater/cooler/display=%b required %b", stSeq[i], {heater, cooler, display}, expSeq[i]);
      else passCount++;
      totalCount++;
      if (heater === 1'b1 && cooler === 1'b1) $display("[TB] FAIL clim_both_st%0d: heater=1 cooler=1 required not both", stSeq[i]);
      else passCount++;
      totalCount++;
    end
    ST = 7'd60;
    step(2);
  endtask

  task automatic test_reset_mid_serve();
    SFD = 1'b1;
    step(5);
    if (fdoor !== 1'b1) $display("[TB] FAIL rst_pre: fdoor=%b required 1", fdoor);
    else passCount++;
    totalCount++;
    #2 Rst = 1'b1;
    #1;
    if (fdoor !== 1'b0 || busy !== 1'b0 || display !== 3'b000) $display("[TB] FAIL rst_async: fdoor=%b busy=%b display=%b required 0/0/000", fdoor, busy, display);
    else passCount++;
    totalCount++;
    SFD = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    step(3);
    if (display !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL rst_release: display=%b busy=%b required 000/0", display, busy);
    else passCount++;
    totalCount++;
    SFD = 1'b1;
    step(4);
    if (fdoor !== 1'b0) $display("[TB] FAIL rst_deb_restart4: fdoor=%b required 0", fdoor);
    else passCount++;
    totalCount++;
    step(1);
    if (fdoor !== 1'b1) $display("[TB] FAIL rst_deb_restart5: fdoor=%b required 1", fdoor);
    else passCount++;
    totalCount++;
    SFD = 1'b0;
  endtask

  initial begin
    Rst = 1'b1;
    {SFD, SRD, SW, SFA, ack} = '0;
    ST = 7'd60;
    step(2);
    test_reset();
    Rst = 1'b0;
    step(2);
    test_glitch();
    test_front_hold();
    test_priority();
    test_fire_preempt();
    test_climate();
    test_reset_mid_serve();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
